// File: rtl/pea_pkg.sv
// pea_pkg: shared types and helpers for the pea_11_mc PE array.
//   state_e       : tile controller states
//   stride_e      : output column decimation selector
//   stride_mask() : per-column keep flags for a given stride and column count
package pea_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STRIDE_S1   = 2'd0,
    STRIDE_S2   = 2'd1,
    STRIDE_S4   = 2'd2,
    STRIDE_RSVD = 2'd3
  } stride_e;

  // Upper bound on array width; callers truncate the result to COL bits.
  localparam int MAX_COL = 256;

  // The reserved encoding falls back to stride 1 (keep every column).
  function automatic logic [MAX_COL-1:0] stride_mask(input stride_e stride, input int col);
    logic [MAX_COL-1:0] m;
    m = '0;
    for (int c = 0; c < MAX_COL; c++) begin
      if (c < col) begin
        case (stride)
          STRIDE_S2: m[c] = ((c % 2) == 0);
          STRIDE_S4: m[c] = ((c % 4) == 0);
          default:   m[c] = 1'b1;
        endcase
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/pea_11_mc_mac.sv
// pe_mac: one signed multiply-accumulate cell.
//   clk, rstn  : clock, async active-low reset (clears acc)
//   en         : accept one product this cycle
//   clr_first  : first input channel of a tile; restart the sum from the product
//   ifm, wgt   : signed DWIDTH operands
//   acc        : running PSUM_WIDTH sum, wraps on overflow
module pe_mac #(
  parameter int DWIDTH     = 8,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  clr_first,
  input  logic [DWIDTH-1:0]     ifm,
  input  logic [DWIDTH-1:0]     wgt,
  output logic [PSUM_WIDTH-1:0] acc
);

  logic signed [2*DWIDTH-1:0]   prod;
  logic signed [PSUM_WIDTH-1:0] prod_ext;

  assign prod     = $signed(ifm) * $signed(wgt);
  assign prod_ext = PSUM_WIDTH'(prod);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clr_first ? '0 : acc) + prod_ext;
    end
  end

endmodule

// File: rtl/pea_11_mc.sv
// pea_11_mc: ROW x COL signed 1x1-conv PE array with multi-output-channel drain.
//   start, cfg_ic_num, cfg_stride : tile kick-off and config (sampled in IDLE)
//   in_valid/in_ready, wgt_group, ifm_group : input beats, one per input channel
//   out_valid/out_ready, out_row, out_data, out_mask : row-by-row result drain
//   busy : not idle;  done : one-cycle pulse after the last row is accepted
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_ACC   | accepting beats, accumulating cfg_ic_num+1 channels
// ST_DRAIN | presenting rows 0..ROW-1 on the output port
module pea_11_mc
  import pea_pkg::*;
#(
  parameter int ROW        = 4,
  parameter int COL        = 8,
  parameter int DWIDTH     = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int ICW        = 12,
  localparam int RW        = (ROW > 1) ? $clog2(ROW) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [ICW-1:0]            cfg_ic_num,
  input  logic [1:0]                cfg_stride,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROW*DWIDTH-1:0]     wgt_group,
  input  logic [COL*DWIDTH-1:0]     ifm_group,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RW-1:0]             out_row,
  output logic [COL*PSUM_WIDTH-1:0] out_data,
  output logic [COL-1:0]            out_mask,
  output logic                      busy,
  output logic                      done
);

  state_e          state_q;
  logic [ICW-1:0]  ic_cnt_q;
  logic [ICW-1:0]  ic_num_q;
  stride_e         stride_q;
  logic [RW-1:0]   row_q;
  logic            done_q;

  logic                  acc_fire;
  logic                  drain_fire;
  logic                  last_beat;
  logic                  last_row;
  logic [COL-1:0]        mask_w;
  logic [PSUM_WIDTH-1:0] acc_w [ROW][COL];

  assign acc_fire   = (state_q == ST_ACC) && in_valid;
  assign drain_fire = (state_q == ST_DRAIN) && out_ready;
  assign last_beat  = (ic_cnt_q == ic_num_q);
  assign last_row   = (row_q == RW'(ROW - 1));
  assign mask_w     = COL'(stride_mask(stride_q, COL));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      ic_cnt_q <= '0;
      ic_num_q <= '0;
      stride_q <= STRIDE_S1;
      row_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            ic_num_q <= cfg_ic_num;
            stride_q <= stride_e'(cfg_stride);
            ic_cnt_q <= '0;
            state_q  <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (acc_fire) begin
            ic_cnt_q <= ic_cnt_q + ICW'(1);
            if (last_beat) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_fire) begin
            if (last_row) begin
              row_q   <= '0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ic_cnt==0 marks the first channel of a tile, so stale sums from the
  // previous tile are discarded without a separate clear cycle.
  for (genvar r = 0; r < ROW; r++) begin : g_row
    for (genvar c = 0; c < COL; c++) begin : g_col
      pe_mac #(
        .DWIDTH     (DWIDTH),
        .PSUM_WIDTH (PSUM_WIDTH)
      ) u_mac (
        .clk       (clk),
        .rstn      (rstn),
        .en        (acc_fire),
        .clr_first (ic_cnt_q == '0),
        .ifm       (ifm_group[c*DWIDTH +: DWIDTH]),
        .wgt       (wgt_group[r*DWIDTH +: DWIDTH]),
        .acc       (acc_w[r][c])
      );
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign out_row   = row_q;
  assign out_mask  = out_valid ? mask_w : '0;

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int c = 0; c < COL; c++) begin
        out_data[c*PSUM_WIDTH +: PSUM_WIDTH] = mask_w[c] ? acc_w[row_q][c] : '0;
      end
    end
  end

endmodule

// File: tb/tb_pea_11_mc.sv
// tb_pea_11_mc: directed bench for pea_11_mc (ROW=4, COL=8, 8-bit data, 32-bit sums).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_pea_11_mc;

  localparam int ROW = 4;
  localparam int COL = 8;
  localparam int DW  = 8;
  localparam int PW  = 32;
  localparam int ICW = 12;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic [ICW-1:0]     cfg_ic_num;
  logic [1:0]         cfg_stride;
  logic               in_valid;
  logic               in_ready;
  logic [ROW*DW-1:0]  wgt_group;
  logic [COL*DW-1:0]  ifm_group;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_row;
  logic [COL*PW-1:0]  out_data;
  logic [COL-1:0]     out_mask;
  logic               busy;
  logic               done;

  int n_cmp = 0;
  int n_mis = 0;
  int mdl [ROW][COL];

  always #5 clk = ~clk;

  pea_11_mc #(
    .ROW(ROW), .COL(COL), .DWIDTH(DW), .PSUM_WIDTH(PW), .ICW(ICW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_ic_num(cfg_ic_num),
    .cfg_stride(cfg_stride), .in_valid(in_valid), .in_ready(in_ready),
    .wgt_group(wgt_group), .ifm_group(ifm_group), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_data(out_data),
    .out_mask(out_mask), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COL*DW-1:0] ifm_const(input logic [7:0] v);
    logic [COL*DW-1:0] f;
    for (int c = 0; c < COL; c++) f[c*DW +: DW] = v;
    return f;
  endfunction

  function automatic logic [COL*DW-1:0] ifm_ramp(input int base);
    logic [COL*DW-1:0] f;
    for (int c = 0; c < COL; c++) f[c*DW +: DW] = 8'(c + base);
    return f;
  endfunction

  function automatic logic [ROW*DW-1:0] wgt_const(input logic [7:0] v);
    logic [ROW*DW-1:0] f;
    for (int r = 0; r < ROW; r++) f[r*DW +: DW] = v;
    return f;
  endfunction

  function automatic logic [ROW*DW-1:0] wgt_ramp(input int base);
    logic [ROW*DW-1:0] f;
    for (int r = 0; r < ROW; r++) f[r*DW +: DW] = 8'(r + base);
    return f;
  endfunction

  task automatic start_tile(input int ic, input logic [1:0] st);
    start      = 1'b1;
    cfg_ic_num = ICW'(ic);
    cfg_stride = st;
    @(negedge clk);
    start      = 1'b0;
    cfg_ic_num = '1;
    cfg_stride = 2'd2;
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++) mdl[r][c] = 0;
    chk("acc_in_ready", in_ready, 1);
    chk("acc_busy", busy, 1);
  endtask

  task automatic beat(input logic [COL*DW-1:0] ifm, input logic [ROW*DW-1:0] wgt);
    logic signed [7:0] a;
    logic signed [7:0] b;
    in_valid  = 1'b1;
    ifm_group = ifm;
    wgt_group = wgt;
    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        a = ifm[c*DW +: DW];
        b = wgt[r*DW +: DW];
        mdl[r][c] = mdl[r][c] + int'(a) * int'(b);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic gap();
    in_valid  = 1'b0;
    ifm_group = {$urandom, $urandom};
    wgt_group = $urandom;
    @(negedge clk);
    chk("gap_in_ready", in_ready, 1);
  endtask

  task automatic drain(input logic [7:0] mask, input int hold_row, input bit poke_start);
    logic [31:0] e;
    for (int r = 0; r < ROW; r++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_row", out_row, 64'(r));
      chk("drain_mask", out_mask, mask);
      chk("drain_in_ready", in_ready, 0);
      for (int c = 0; c < COL; c++) begin
        e = mask[c] ? mdl[r][c] : 32'd0;
        chk($sformatf("drain_r%0d_c%0d", r, c), out_data[c*PW +: PW], e);
      end
      if (r == hold_row) begin
        for (int k = 0; k < 5; k++) begin
          out_ready = 1'b0;
          @(negedge clk);
          chk("hold_row", out_row, 64'(r));
          for (int c = 0; c < COL; c++) begin
            e = mask[c] ? mdl[r][c] : 32'd0;
            chk($sformatf("hold_r%0d_c%0d", r, c), out_data[c*PW +: PW], e);
          end
        end
      end
      if (poke_start && (r == 0 || r == ROW - 1)) begin
        start      = 1'b1;
        cfg_ic_num = 12'd5;
        cfg_stride = 2'd1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("done_out_valid", out_valid, 0);
    chk("done_out_row", out_row, 0);
    chk("done_mask", out_mask, 0);
    chk("done_busy", busy, 0);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    cfg_ic_num = '0;
    cfg_stride = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    wgt_group  = '0;
    ifm_group  = '0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_mask", out_mask, 0);
    chk("rst_out_data_zero", out_data == '0, 1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Basic: 3 channels of ones times row weight r+1 -> 3,6,9,12.
    start_tile(2, 2'd0);
    repeat (3) beat(ifm_const(8'd1), wgt_ramp(1));
    chk("t1_r0_c0", out_data[31:0], 32'd3);
    chk("t1_r0_c7", out_data[255:224], 32'd3);
    drain(8'hFF, -1, 1'b0);

    // Signed extremes and a negative product; the second tile must not see the first.
    start_tile(0, 2'd0);
    beat(ifm_const(8'h80), wgt_const(8'h80));
    chk("t2_min_c0", out_data[31:0], 32'd16384);
    chk("t2_min_c7", out_data[255:224], 32'd16384);
    drain(8'hFF, -1, 1'b0);
    start_tile(0, 2'd0);
    beat(ifm_const(8'hFD), wgt_const(8'h05));
    chk("t2_neg_c0", out_data[31:0], 32'hFFFF_FFF1);
    drain(8'hFF, -1, 1'b0);

    // Stride masks with ifm column c = c+1.
    start_tile(0, 2'd1);
    beat(ifm_ramp(1), wgt_const(8'd1));
    chk("s2_mask", out_mask, 8'h55);
    chk("s2_c1", out_data[63:32], 32'd0);
    chk("s2_c2", out_data[95:64], 32'd3);
    drain(8'h55, -1, 1'b0);
    start_tile(0, 2'd2);
    beat(ifm_ramp(1), wgt_const(8'd1));
    chk("s4_mask", out_mask, 8'h11);
    chk("s4_c4", out_data[159:128], 32'd5);
    drain(8'h11, -1, 1'b0);
    start_tile(0, 2'd3);
    beat(ifm_ramp(1), wgt_const(8'd1));
    chk("rsvd_mask", out_mask, 8'hFF);
    drain(8'hFF, -1, 1'b0);

    // Input gaps, output backpressure on row 1, start pokes during drain and on done.
    start_tile(3, 2'd0);
    beat(ifm_ramp(-4), wgt_ramp(1));
    gap();
    beat(ifm_ramp(2), wgt_const(8'hFF));
    gap();
    beat(ifm_const(8'h7F), wgt_ramp(-2));
    gap();
    beat(ifm_ramp(0), wgt_const(8'd3));
    chk("gap_r0_c0", out_data[31:0], 32'hFFFF_FEFC);
    drain(8'hFF, 1, 1'b1);

    // Same tile without gaps must give the same sums.
    start_tile(3, 2'd0);
    beat(ifm_ramp(-4), wgt_ramp(1));
    beat(ifm_ramp(2), wgt_const(8'hFF));
    beat(ifm_const(8'h7F), wgt_ramp(-2));
    beat(ifm_ramp(0), wgt_const(8'd3));
    chk("nogap_r0_c0", out_data[31:0], 32'hFFFF_FEFC);
    drain(8'hFF, -1, 1'b0);

    // Reset in the middle of accumulation, then a fresh 2-channel tile.
    start_tile(3, 2'd0);
    beat(ifm_const(8'd50), wgt_const(8'd7));
    beat(ifm_const(8'd50), wgt_const(8'd7));
    rstn = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_mask", out_mask, 0);
    chk("abort_out_data_zero", out_data == '0, 1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_abort_idle", busy, 0);
    start_tile(1, 2'd0);
    beat(ifm_ramp(1), wgt_ramp(1));
    beat(ifm_const(8'd2), wgt_const(8'd1));
    chk("abort_r0_c0", out_data[31:0], 32'd3);
    drain(8'hFF, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
